// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: word sizes, SubBytes FSM encoding and a
// byte-slice helper (byte 0 is the most significant byte, FIPS-197 order).
package aes_pkg;

    localparam int unsigned AES_STATE_BYTES = 16;
    localparam int unsigned AES_WORD_BYTES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sb_state_t;

    // MSB position of byte i inside a w-bit word; use as word[byte_msb(w, i) -: 8].
    function automatic int unsigned byte_msb(input int unsigned w, input int unsigned i);
        return w - 1 - 8 * i;
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box ROM with a registered read (1-cycle latency, no reset).
// Ports:
//   clk       rising-edge clock
//   din[7:0]  lookup address (byte to substitute)
//   dout[7:0] substituted byte, valid one cycle after din
module sbox (
    input  logic       clk,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX_ROM [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Registered lookup.
    always_ff @(posedge clk) begin
        dout <= SBOX_ROM[din];
    end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative forward SubBytes: accepts an NBYTES-byte word, substitutes one
// byte per cycle through a single shared S-box ROM, returns the result word.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready high only in IDLE)
//   din[8*NBYTES-1:0]     input word, byte 0 in the top byte
//   out_valid / out_ready output handshake
//   dout[8*NBYTES-1:0]    substituted word, same byte order as din
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned NBYTES = AES_STATE_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   dout
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = $clog2(NBYTES + 1);

    sb_state_t      state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   word_q;   // captured word, shifted so the next byte sits on top
    logic [W-1:0]   res_q;    // results shifted in byte 0 first
    logic [7:0]     sbox_addr;
    logic [7:0]     sbox_q;

    assign in_ready = (state == ST_IDLE);

    // Top byte of the shifted word is byte[cnt] while lookups are still issuing.
    assign sbox_addr = (state == ST_RUN && cnt < CW'(NBYTES)) ? word_q[W-1 -: 8] : 8'h00;

    sbox u_sbox (
        .clk  (clk),
        .din  (sbox_addr),
        .dout (sbox_q)
    );

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            word_q    <= '0;
            res_q     <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_q <= din;
                        res_q  <= '0;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt < CW'(NBYTES)) begin
                        word_q <= word_q << 8;
                    end
                    // A lookup issued last cycle returns whenever cnt is nonzero.
                    if (cnt != '0) begin
                        res_q <= (res_q << 8) | W'(sbox_q);
                    end
                    if (cnt == CW'(NBYTES)) begin
                        dout      <= (res_q << 8) | W'(sbox_q);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: one 16-byte and one 4-byte instance, each shadowed
// by a transaction-level model whose S-box is derived from GF(2^8) arithmetic.
module tb_sub_bytes_iter;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         iv16, ir16, ov16, or16;
    logic [127:0] din16, dout16;
    logic         iv4, ir4, ov4, or4;
    logic [31:0]  din4, dout4;

    sub_bytes_iter #(.NBYTES(AES_STATE_BYTES)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .din(din16),
        .out_valid(ov16), .out_ready(or16), .dout(dout16)
    );

    sub_bytes_iter #(.NBYTES(AES_WORD_BYTES)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .din(din4),
        .out_valid(ov4), .out_ready(or4), .dout(dout4)
    );

    int checks = 0;
    int errors = 0;
    logic run_cmp = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference S-box from field arithmetic ----------------
    logic [7:0] sb_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_word(input logic [127:0] w, input int nb);
        logic [127:0] r = '0;
        for (int j = 0; j < nb; j++)
            r = r | (128'(sb_m[8'(w >> (8 * j))]) << (8 * j));
        return r;
    endfunction

    // ---------------- transaction model: idle -> busy N+1 edges -> hold ----------------
    int           m_st [2];
    int           m_k  [2];
    logic [127:0] m_w  [2];
    logic [127:0] m_d  [2];
    logic         m_v  [2];

    task automatic step(input int i, input int nb, input logic vin, input logic ordy,
                        input logic [127:0] dn);
        case (m_st[i])
            0: if (vin) begin m_w[i] = dn; m_k[i] = 0; m_st[i] = 1; end
            1: begin
                m_k[i]++;
                if (m_k[i] == nb + 1) begin
                    m_d[i] = sub_word(m_w[i], nb); m_v[i] = 1'b1; m_st[i] = 2;
                end
            end
            2: if (ordy) begin m_v[i] = 1'b0; m_st[i] = 0; end
            default: m_st[i] = 0;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_k[i] = 0; m_v[i] = 1'b0; m_d[i] = '0; m_w[i] = '0;
            end
        end else begin
            step(0, 16, iv16, or16, din16);
            step(1, 4, iv4, or4, 128'(din4));
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("in_ready16",  128'(ir16), 128'(m_st[0] == 0));
            chk("out_valid16", 128'(ov16), 128'(m_v[0]));
            chk("dout16",      dout16,     m_d[0]);
            chk("in_ready4",   128'(ir4),  128'(m_st[1] == 0));
            chk("out_valid4",  128'(ov4),  128'(m_v[1]));
            chk("dout4",       128'(dout4), 128'(m_d[1][31:0]));
        end
    end

    // ---------------- drivers ----------------
    task automatic send16(input logic [127:0] w);
        int n = 0;
        @(negedge clk);
        while (!ir16 && n < 200) begin @(negedge clk); n++; end
        if (!ir16) begin
            checks++; errors++;
            $display("FAIL send16: in_ready stuck low, got 0 expected 1");
        end
        iv16 = 1'b1; din16 = w;
        @(negedge clk);
        iv16 = 1'b0; din16 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send4(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (!ir4 && n < 200) begin @(negedge clk); n++; end
        if (!ir4) begin
            checks++; errors++;
            $display("FAIL send4: in_ready stuck low, got 0 expected 1");
        end
        iv4 = 1'b1; din4 = w;
        @(negedge clk);
        iv4 = 1'b0; din4 = $urandom;
    endtask

    // Returns number of edges from the accept edge to out_valid becoming visible.
    task automatic wait_out16(output int n);
        n = 0;
        while (!ov16 && n < 60) begin @(negedge clk); n++; end
        if (!ov16) begin
            checks++; errors++;
            $display("FAIL wait_out16: timeout, got out_valid 0 expected 1");
        end
    endtask

    task automatic wait_out4(output int n);
        n = 0;
        while (!ov4 && n < 60) begin @(negedge clk); n++; end
        if (!ov4) begin
            checks++; errors++;
            $display("FAIL wait_out4: timeout, got out_valid 0 expected 1");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [127:0] w, w1, w2;

        iv16 = 1'b0; or16 = 1'b0; din16 = '0;
        iv4  = 1'b0; or4  = 1'b0; din4  = '0;

        for (int v = 0; v < 256; v++) sb_m[v] = sbox_calc(8'(v));

        // Pin the reference model with hand-known values.
        chk("model_sbox_00", 128'(sb_m[8'h00]), 128'(8'h63));
        chk("model_sbox_01", 128'(sb_m[8'h01]), 128'(8'h7c));
        chk("model_sbox_53", 128'(sb_m[8'h53]), 128'(8'hed));
        chk("model_sbox_ff", 128'(sb_m[8'hff]), 128'(8'h16));
        chk("model_sbox_19", 128'(sb_m[8'h19]), 128'(8'hd4));
        chk("model_appb", sub_word(128'h193de3bea0f4e22b9ac68d2ae9f84808, 16),
            128'hd42711aee0bf98f1b8b45de51e415230);

        // Reset, no stimulus.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;
        @(negedge clk);
        chk("rst_in_ready16",  128'(ir16), 128'(1'b1));
        chk("rst_out_valid16", 128'(ov16), 128'(1'b0));
        chk("rst_dout16",      dout16,     128'h0);
        chk("rst_in_ready4",   128'(ir4),  128'(1'b1));
        chk("rst_dout4",       128'(dout4), 128'h0);

        // FIPS-197 App. B round-1 SubBytes.
        or16 = 1'b1;
        send16(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        wait_out16(lat);
        chk("latency16", 128'(lat), 128'(17));
        chk("appb_dout16", dout16, 128'hd42711aee0bf98f1b8b45de51e415230);
        @(negedge clk);
        chk("in_ready_after_hs16", 128'(ir16), 128'(1'b1));

        // 4-byte SubWord, then back-to-back stream with out_ready held.
        or4 = 1'b1;
        send4(32'h000102ff);
        wait_out4(lat);
        chk("latency4", 128'(lat), 128'(5));
        chk("subword_dout4", 128'(dout4), 128'(32'h637c7716));
        iv4 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            din4 = $urandom;
            @(negedge clk);
        end
        iv4 = 1'b0;
        repeat (8) @(negedge clk);

        // Backpressure: result held, new input ignored.
        or16 = 1'b0;
        w1 = {$urandom, $urandom, $urandom, $urandom};
        w2 = {$urandom, $urandom, $urandom, $urandom};
        send16(w1);
        wait_out16(lat);
        for (int c = 0; c < 10; c++) begin
            iv16 = 1'b1; din16 = ~din16;
            @(negedge clk);
            chk("bp_in_ready16", 128'(ir16), 128'(1'b0));
            chk("bp_dout16", dout16, sub_word(w1, 16));
        end
        din16 = w2; or16 = 1'b1;
        @(negedge clk);   // handshake edge
        @(negedge clk);   // accept edge for w2
        iv16 = 1'b0;
        wait_out16(lat);
        chk("bp_next_dout16", dout16, sub_word(w2, 16));
        @(negedge clk);

        // Reset in the 8th RUN cycle, then a clean word.
        send16({$urandom, $urandom, $urandom, $urandom});
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid16", 128'(ov16), 128'(1'b0));
        chk("midrst_dout16",      dout16,     128'h0);
        chk("midrst_in_ready16",  128'(ir16), 128'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        send16({16{8'h53}});
        wait_out16(lat);
        chk("after_rst_dout16", dout16, {16{8'hed}});
        @(negedge clk);

        // Every byte value, 16 per word, checked per byte position.
        for (int k = 0; k < 16; k++) begin
            w = '0;
            for (int j = 0; j < 16; j++) w = (w << 8) | 128'(16 * k + j);
            send16(w);
            wait_out16(lat);
            for (int j = 0; j < 16; j++)
                chk("exh_byte", 128'(8'(dout16 >> (8 * (15 - j)))),
                    128'(sb_m[8'(16 * k + j)]));
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
